sync_perf_event_tracker: RTL
============================

// Module: sync_perf_event_tracker
// PURPOSE
// Per-thread barrier lifecycle tracker in the tile synchronization path. Observes barrier-core issue,
// account-request network handshake and release messages, and drives the two per-thread level
// events (detect, send) consumed by the tile performance counter. Each event is high for exactly
// the cycles of its phase, so the counter measures send latency and barrier wait time per thread.
// PARAMETERS
// THREAD_NUMB    `THREAD_NUMB  hardware threads tracked, one FSM each
// WAIT_TIMEOUT   1024          WAIT cycles before wait_timeout pulses (SYNC_PERF_TIMEOUT_EN only)
// PORTS
// clk                 in   1                 clock
// reset               in   1                 async, active-high
// bc_issue_valid      in   1                 barrier_core instruction issued
// bc_issue_thread_id  in   thread_id_t       issuing thread
// bc_issue_barrier_id in   barrier_t         barrier id of issued instruction
// acc_req_valid       in   1                 account request offered to network
// acc_req_ready       in   1                 network accepts account request
// acc_req_thread_id   in   thread_id_t       thread owning offered request
// release_valid       in   1                 release message from sync master
// release_thread_mask in   THREAD_NUMB       threads released by that message
// perf_events         out  [1:0][THREAD_NUMB] [0]=detect (WAIT), [1]=send (SEND)
// thread_barrier_id   out  barrier_t x THREAD_NUMB  id latched at issue, per thread
// protocol_error      out  1                 sticky; set on any illegal event
// wait_timeout        out  THREAD_NUMB       1-cycle pulse per thread on WAIT timeout
// BEHAVIOUR
// - Reset: all FSMs IDLE, pending=0, perf_events=0, thread_barrier_id=0, protocol_error=0, wait_timeout=0.
// - Per-thread FSM states: IDLE, SEND, WAIT, GAP1, GAP2. Outputs decoded from registered state only.
// - send[i]=1 iff state SEND; detect[i]=1 iff state WAIT. Never both high.
// - IDLE: issue for thread i at cycle t -> SEND at t+1; barrier id latched at t+1.
// - SEND: acc_req_valid&&acc_req_ready for thread i at t -> WAIT at t+1.
// - WAIT: release_valid&&release_thread_mask[i] at t -> GAP1 at t+1.
// - GAP1->GAP2->IDLE unconditionally: guarantees 2 low cycles so counter displays and clears.
// - Issue during GAP1/GAP2: set pending[i], latch barrier id; GAP2 exits to SEND instead of IDLE.
// - SEND with accept and release in same cycle: -> GAP1 directly (zero-length wait, detect never high).
// - Illegal, ignored, set protocol_error next cycle: issue in SEND/WAIT or with pending set; accept
//   for thread not in SEND; release bit for thread not in WAIT/SEND; acc_req_ready without valid ignored.
// - Multiple threads may change state in same cycle; release mask may free several threads at once.
// - Reset mid-operation: all threads return to IDLE immediately, events drop asynchronously.
// CONFIGURATION
// - SYNC_PERF_TIMEOUT_EN defined: per-thread wait counter, $clog2(WAIT_TIMEOUT+1) bits, cleared on
//   WAIT entry, saturating; wait_timeout[i] pulses once when WAIT reaches WAIT_TIMEOUT cycles; FSM
//   unaffected (thread stays WAIT).
// - Not defined: no wait counters; wait_timeout tied to 0.
// STRUCTURE
// - npu_synchronization_defines.sv: typedef enum perf_trk_state_t {IDLE,SEND,WAIT,GAP1,GAP2};
//   localparam PERF_EV_DETECT=0, PERF_EV_SEND=1 (shared with performance counter indexing).
// - Sub-module sync_perf_thread_fsm: one thread's FSM, pending bit, id latch, timeout counter;
//   top generates THREAD_NUMB instances, decodes thread ids to one-hot, ORs error strobes.
// TESTING
// - T2 issue id 5 @c10, accept @c14, release @c30 -> send[2]=1 c11..c14, detect[2]=1 c15..c30, id=5.
// - T0 release @c20, T0 issue again @c21 -> pending; SEND at c23, no gap <2 low cycles on detect.
// - T1,T3 both WAIT, release mask 0b1010 -> both to GAP1 next cycle, same timing.
// - T4 SEND, accept+release same cycle -> GAP1 next cycle, detect[4] never high, no error.
// - Issue T6 while T6 in WAIT; release to IDLE T7 -> protocol_error=1, T6/T7 states unchanged.
// - SYNC_PERF_TIMEOUT_EN, WAIT_TIMEOUT=8: T5 waits 20 cycles -> single pulse on 8th WAIT cycle;
//   reset asserted mid-WAIT -> perf_events=0 immediately.

Source files
------------

// File: rtl/sync_perf_event_tracker_pkg.sv
// Shared definitions for the per-thread barrier lifecycle tracker.
// Provides the tracker state encoding, id widths and the event row indices
// used by the tile performance counter when indexing perf_events.
package sync_perf_event_tracker_pkg;

  localparam int unsigned THREAD_NUMB_DEF = 8;
  localparam int unsigned THREAD_ID_W     = $clog2(THREAD_NUMB_DEF);
  localparam int unsigned BARRIER_W       = 6;

  typedef logic [THREAD_ID_W-1:0] thread_id_t;
  typedef logic [BARRIER_W-1:0]   barrier_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    GAP1,
    GAP2
  } perf_trk_state_t;

  // Row indices into perf_events, shared with the performance counter.
  localparam int unsigned PERF_EV_DETECT = 0;
  localparam int unsigned PERF_EV_SEND   = 1;

endpackage

// File: rtl/sync_perf_event_tracker_thread_fsm.sv
// One thread's barrier lifecycle FSM: IDLE -> SEND -> WAIT -> GAP1 -> GAP2 -> IDLE.
// Holds the pending re-issue bit, the latched barrier id and, when SYNC_PERF_TIMEOUT_EN
// is defined, a saturating WAIT-cycle counter driving a one-shot timeout pulse.
// Ports:
//   clk, reset          clock, async active-high reset
//   issue_hit           barrier_core issue addressed to this thread
//   issue_barrier_id    barrier id carried by that issue
//   accept_hit          account request for this thread accepted by the network
//   release_hit         release message frees this thread
//   send, detect        level events: state SEND / state WAIT
//   barrier_id          id latched at issue
//   error               combinational strobe: an event illegal in the current state
//   wait_timeout        1-cycle pulse on the WAIT_TIMEOUT-th WAIT cycle
module sync_perf_event_tracker_thread_fsm
  import sync_perf_event_tracker_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 1024
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     issue_hit,
  input  barrier_t issue_barrier_id,
  input  logic     accept_hit,
  input  logic     release_hit,
  output logic     send,
  output logic     detect,
  output barrier_t barrier_id,
  output logic     error,
  output logic     wait_timeout
);

  perf_trk_state_t state_q, state_d;
  logic            pending_q, pending_d;
  barrier_t        barrier_id_q, barrier_id_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      barrier_id_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      barrier_id_q <= barrier_id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    barrier_id_d = barrier_id_q;
    unique case (state_q)
      IDLE: begin
        if (issue_hit) begin
          state_d      = SEND;
          barrier_id_d = issue_barrier_id;
        end
      end
      SEND: begin
        // Accept and release together means the barrier was already complete.
        if (accept_hit) state_d = release_hit ? GAP1 : WAIT;
      end
      WAIT: begin
        if (release_hit) state_d = GAP1;
      end
      GAP1: begin
        state_d = GAP2;
        if (issue_hit && !pending_q) begin
          pending_d    = 1'b1;
          barrier_id_d = issue_barrier_id;
        end
      end
      GAP2: begin
        if (pending_q) begin
          state_d   = SEND;
          pending_d = 1'b0;
        end else if (issue_hit) begin
          state_d      = SEND;
          barrier_id_d = issue_barrier_id;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Illegal events are ignored by the FSM above and only reported here.
  always_comb begin
    error = 1'b0;
    if (issue_hit && ((state_q == SEND) || (state_q == WAIT) || pending_q)) error = 1'b1;
    if (accept_hit && (state_q != SEND)) error = 1'b1;
    if (release_hit && (state_q != SEND) && (state_q != WAIT)) error = 1'b1;
  end

  assign send       = (state_q == SEND);
  assign detect     = (state_q == WAIT);
  assign barrier_id = barrier_id_q;

`ifdef SYNC_PERF_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(WAIT_TIMEOUT + 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  // wait_cnt_q holds the number of WAIT cycles already completed, saturating.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_q != WAIT) && (state_d == WAIT)) begin
      wait_cnt_d = '0;
    end else if ((state_q == WAIT) && (wait_cnt_q != CntW'(WAIT_TIMEOUT))) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  assign wait_timeout = (state_q == WAIT) && (wait_cnt_q == CntW'(WAIT_TIMEOUT - 1));
`else
  logic [31:0] unused_wait_timeout;
  assign unused_wait_timeout = WAIT_TIMEOUT;
  assign wait_timeout        = 1'b0;
`endif

endmodule

// File: rtl/sync_perf_event_tracker.sv
// Per-thread barrier lifecycle tracker feeding the tile performance counter.
// Decodes barrier_core issues, accepted account requests and release messages per thread,
// runs one lifecycle FSM per thread and exports the detect (WAIT) and send (SEND) level events.
// Optional feature: define SYNC_PERF_TIMEOUT_EN to enable per-thread WAIT timeout pulses.
// Ports:
//   clk, reset            clock, async active-high reset
//   bc_issue_*            barrier_core issue strobe, thread id, barrier id
//   acc_req_*             account request handshake and owning thread
//   release_valid/mask    release message and the set of threads it frees
//   perf_events           [PERF_EV_DETECT]=WAIT per thread, [PERF_EV_SEND]=SEND per thread
//   thread_barrier_id     barrier id latched at issue, per thread
//   protocol_error        sticky flag for any illegal event
//   wait_timeout          per-thread 1-cycle WAIT timeout pulse
module sync_perf_event_tracker
  import sync_perf_event_tracker_pkg::*;
#(
  parameter int unsigned THREAD_NUMB  = THREAD_NUMB_DEF,
  parameter int unsigned WAIT_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bc_issue_valid,
  input  thread_id_t                   bc_issue_thread_id,
  input  barrier_t                     bc_issue_barrier_id,
  input  logic                         acc_req_valid,
  input  logic                         acc_req_ready,
  input  thread_id_t                   acc_req_thread_id,
  input  logic                         release_valid,
  input  logic [THREAD_NUMB-1:0]       release_thread_mask,
  output logic [1:0][THREAD_NUMB-1:0]  perf_events,
  output barrier_t [THREAD_NUMB-1:0]   thread_barrier_id,
  output logic                         protocol_error,
  output logic [THREAD_NUMB-1:0]       wait_timeout
);

  logic [THREAD_NUMB-1:0] issue_hit, accept_hit, release_hit;
  logic [THREAD_NUMB-1:0] send, detect, thread_err;
  logic                   acc_fire;
  logic                   protocol_error_q;

  // A ready without valid is not a handshake and is dropped here.
  assign acc_fire    = acc_req_valid && acc_req_ready;
  assign release_hit = release_valid ? release_thread_mask : '0;

  for (genvar i = 0; i < THREAD_NUMB; i++) begin : g_thread
    assign issue_hit[i]  = bc_issue_valid && (bc_issue_thread_id == thread_id_t'(i));
    assign accept_hit[i] = acc_fire && (acc_req_thread_id == thread_id_t'(i));

    sync_perf_event_tracker_thread_fsm #(
      .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_fsm (
      .clk              (clk),
      .reset            (reset),
      .issue_hit        (issue_hit[i]),
      .issue_barrier_id (bc_issue_barrier_id),
      .accept_hit       (accept_hit[i]),
      .release_hit      (release_hit[i]),
      .send             (send[i]),
      .detect           (detect[i]),
      .barrier_id       (thread_barrier_id[i]),
      .error            (thread_err[i]),
      .wait_timeout     (wait_timeout[i])
    );
  end

  assign perf_events[PERF_EV_DETECT] = detect;
  assign perf_events[PERF_EV_SEND]   = send;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            protocol_error_q <= 1'b0;
    else if (|thread_err) protocol_error_q <= 1'b1;
  end

  assign protocol_error = protocol_error_q;

endmodule
